// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch types: command and result records, FIFO sizing defaults and the fetch FSM states.
// Latency: none (types only).
// Backpressure: n/a.
package processor_help;

    typedef logic [24:0] Word;

    // Encoding 2'b11 is not named and behaves as STALL.
    typedef enum logic [1:0] {
        DEQUEUE  = 2'b00,
        STALL    = 2'b01,
        REDIRECT = 2'b10
    } FetchOperation;

    typedef struct packed {
        FetchOperation operation;
        Word           redirect_pc;
    } FetchRequest;

    typedef struct packed {
        Word program_counter;
        Word instruction;
    } FetchResult;

    localparam int FETCH_QUEUE_DEPTH  = 4;
    localparam int FETCH_MAX_INFLIGHT = 4;

    typedef enum logic {
        RUNNING  = 1'b0,
        DRAINING = 1'b1
    } FetchState;

endpackage

// File: rtl/instruction_fetch_unit_queue.sv
// FIFO of FetchResult with flush; head is read combinationally from storage.
// Latency: a push becomes visible at head on the cycle after it is written (no bypass).
// Backpressure: none internally; the caller must not push when full.
module fetch_queue
    import processor_help::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  FetchResult               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output FetchResult               head,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    // The extra top pointer bit separates full (bits differ) from empty (bits equal).
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    FetchResult  mem [DEPTH];

    assign occupancy = wr_ptr - rd_ptr;
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head      = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, issues in-order word reads and queues results for decode (stats under FETCH_STATS_EN).
// Latency: request accepted at t, response at t+L -> fetch_result_valid at t+L+1.
// Backpressure: a request issues only while occupancy + in-flight reads < QUEUE_DEPTH and in-flight < MAX_INFLIGHT.
module instruction_fetch_unit
    import processor_help::*;
#(
    parameter int  QUEUE_DEPTH  = FETCH_QUEUE_DEPTH,
    parameter int  MAX_INFLIGHT = FETCH_MAX_INFLIGHT,
    parameter Word RESET_PC     = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  FetchRequest fetch_request,
    output FetchResult  fetch_result,
    output logic        fetch_result_valid,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output Word         imem_req_address,
    input  logic        imem_resp_valid,
    input  Word         imem_resp_data
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_redirects
`endif
);
    localparam int OW = $clog2(QUEUE_DEPTH) + 1;
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    FetchState     state;
    FetchState     state_d;
    Word           fetch_pc;
    Word           resp_pc;
    logic [IW-1:0] inflight;
    logic [IW-1:0] inflight_d;
    logic [IW-1:0] discard;
    logic [IW-1:0] discard_d;
    logic [OW-1:0] occupancy;
    logic          q_empty;
    logic          q_full;
    logic          req_fire;
    logic          is_redirect;
    logic          push;
    logic          pop;
    FetchResult    push_data;

    assign is_redirect = fetch_request.operation == REDIRECT;

    // Every in-flight read owns a FIFO slot, so a response can always be pushed.
    assign imem_req_valid   = (int'(occupancy) + int'(inflight) < QUEUE_DEPTH)
                           && (int'(inflight) < MAX_INFLIGHT);
    assign imem_req_address = fetch_pc;
    assign req_fire         = imem_req_valid && imem_req_ready;

    assign push      = imem_resp_valid && (state == RUNNING) && !is_redirect;
    assign pop       = (fetch_request.operation == DEQUEUE) && !q_empty;
    assign push_data = '{program_counter: resp_pc, instruction: imem_resp_data};

    assign fetch_result_valid = !q_empty;

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .flush    (is_redirect),
        .head     (fetch_result),
        .occupancy(occupancy),
        .empty    (q_empty),
        .full     (q_full)
    );

    always_comb begin
        inflight_d = inflight;
        if (req_fire && !imem_resp_valid) begin
            inflight_d = inflight + IW'(1);
        end else if (!req_fire && imem_resp_valid) begin
            inflight_d = inflight - IW'(1);
        end
    end

    // On redirect every read still outstanding after this cycle is stale, including one accepted now.
    always_comb begin
        state_d   = state;
        discard_d = discard;
        if (is_redirect) begin
            discard_d = inflight_d;
            state_d   = (inflight_d != '0) ? DRAINING : RUNNING;
        end else if (imem_resp_valid && (state == DRAINING)) begin
            discard_d = discard - IW'(1);
            if (discard == IW'(1)) begin
                state_d = RUNNING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUNNING;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            state    <= state_d;
            inflight <= inflight_d;
            discard  <= discard_d;
            if (is_redirect) begin
                fetch_pc <= fetch_request.redirect_pc;
                resp_pc  <= fetch_request.redirect_pc;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 25'd1;
                end
                if (push) begin
                    resp_pc <= resp_pc + 25'd1;
                end
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched   <= '0;
            stat_redirects <= '0;
        end else begin
            if (push && (stat_fetched != '1)) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (is_redirect && (stat_redirects != '1)) begin
                stat_redirects <= stat_redirects + 32'd1;
            end
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && q_full));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised bench for instruction_fetch_unit with an in-bench memory and a scoreboard of expected results.
// Latency: n/a. Backpressure: memory ready is randomised.
module tb_instruction_fetch_unit;
    import processor_help::*;

    logic        clk = 1'b0;
    logic        rst_n;
    FetchRequest fetch_request;
    FetchResult  fetch_result;
    logic        fetch_result_valid;
    logic        imem_req_valid;
    logic        imem_req_ready;
    Word         imem_req_address;
    logic        imem_resp_valid;
    Word         imem_resp_data;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_redirects;
`endif

    instruction_fetch_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_request     (fetch_request),
        .fetch_result      (fetch_result),
        .fetch_result_valid(fetch_result_valid),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_address  (imem_req_address),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched      (stat_fetched),
        .stat_redirects    (stat_redirects)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        Word addr;
        int  due;
        int  epoch;
    } pend_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         epoch    = 0;
    int         last_due = -1;
    int         lat_min  = 1;
    int         lat_max  = 1;
    int         model_fetched   = 0;
    int         model_redirects = 0;
    Word        exp_addr;
    pend_t      pend_q[$];
    FetchResult sb_q[$];
    Word        popped[$];

    // Memory contents: a fixed bijection of the address so every word is distinct.
    function automatic Word mem_data(input Word a);
        return {a[12:0], a[24:13]} ^ 25'h15A5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock cycle of stimulus: memory model, expected-stream bookkeeping, then the edge.
    task automatic cycle(input FetchOperation op, input Word tgt, input logic rdy);
        pend_t p;
        int    due;
        logic  redir;
        redir                     = (op == REDIRECT);
        fetch_request.operation   = op;
        fetch_request.redirect_pc = tgt;
        imem_req_ready            = rdy;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p               = pend_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(p.addr);
            if (p.epoch == epoch && !redir) model_fetched++;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        if (imem_req_valid && rdy) begin
            chk("req_address", imem_req_address, exp_addr);
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_q.push_back('{addr: exp_addr, due: due, epoch: epoch});
            sb_q.push_back('{program_counter: exp_addr, instruction: mem_data(exp_addr)});
            exp_addr = exp_addr + 25'd1;
        end
        if (redir) begin
            sb_q.delete();
            exp_addr = tgt;
            epoch++;
            model_redirects++;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && pend_q.size() > 0; i++) cycle(STALL, '0, 1'b0);
    endtask

    task automatic expect_first(input string name, input Word pc, input int n);
        Word nxt;
        nxt = pc + 25'd1;
        popped.delete();
        for (int i = 0; i < n; i++) cycle(DEQUEUE, '0, 1'b1);
        chk({name, "_count"}, popped.size() >= 2, 1);
        if (popped.size() >= 2) begin
            chk({name, "_first_pc"}, popped[0], pc);
            chk({name, "_second_pc"}, popped[1], nxt);
        end
    endtask

    task automatic check_stats(input string name);
`ifdef FETCH_STATS_EN
        chk({name, "_stat_fetched"}, stat_fetched, model_fetched);
        chk({name, "_stat_redirects"}, stat_redirects, model_redirects);
`else
        chk({name, "_valid_known"}, $isunknown(fetch_result_valid), 0);
`endif
    endtask

    // Monitor: every DEQUEUE against a non-empty FIFO consumes the oldest expected result.
    initial begin
        FetchResult e;
        forever begin
            @(negedge clk);
            if (rst_n && fetch_request.operation == DEQUEUE && fetch_result_valid) begin
                chk("result_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("result_pc", fetch_result.program_counter, e.program_counter);
                    chk("result_instr", fetch_result.instruction, e.instruction);
                    popped.push_back(fetch_result.program_counter);
                end
            end
        end
    end

    initial begin
        FetchOperation op;
        Word           tgt;
        int            r;
        logic          found;

        rst_n                     = 1'b0;
        fetch_request.operation   = STALL;
        fetch_request.redirect_pc = '0;
        imem_req_ready            = 1'b0;
        imem_resp_valid           = 1'b0;
        imem_resp_data            = '0;
        exp_addr                  = '0;
        #2;
        chk("rst_result_valid", fetch_result_valid, 0);
        chk("rst_result", fetch_result, 0);
        chk("rst_req_address", imem_req_address, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_req_valid", imem_req_valid, 1);

        // Fill with latency 1 while decode stalls: four reads, then the credit runs out.
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) cycle(STALL, '0, 1'b1);
        chk("t1_req_valid_full", imem_req_valid, 0);
        chk("t1_accepted", sb_q.size(), 4);
        chk("t1_result_valid", fetch_result_valid, 1);
        chk("t1_head_pc", fetch_result.program_counter, 0);

        // Steady dequeue with latency 2: no bubbles once the pipe is primed.
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 8; i++) cycle(DEQUEUE, '0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chk("t2_no_bubble", fetch_result_valid, 1);
            cycle(DEQUEUE, '0, 1'b1);
        end

        // Two reads in flight, then redirect: both responses must vanish.
        drain();
        cycle(REDIRECT, 25'h050, 1'b0);
        lat_min = 5; lat_max = 5;
        cycle(STALL, '0, 1'b1);
        cycle(STALL, '0, 1'b1);
        chk("t3_two_inflight_valid", imem_req_valid, 1);
        cycle(REDIRECT, 25'h100, 1'b0);
        chk("t3_flushed", fetch_result_valid, 0);
        expect_first("t3", 25'h100, 15);
        check_stats("t3");

        // Redirect in a cycle that both accepts a request and receives a response.
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) cycle(DEQUEUE, '0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (imem_req_valid && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                found = 1'b1;
                cycle(REDIRECT, 25'h2A0, 1'b1);
            end else begin
                cycle(STALL, '0, 1'b1);
            end
        end
        chk("t4_collision_found", found, 1);
        expect_first("t4", 25'h2A0, 15);

        // Redirect to the last word: PC wraps to zero.
        cycle(REDIRECT, 25'h1FFFFFF, 1'b1);
        expect_first("t5", 25'h1FFFFFF, 12);

        // Empty FIFO with DEQUEUE, then the undefined encoding holding a full queue.
        drain();
        cycle(REDIRECT, 25'h300, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(DEQUEUE, '0, 1'b0);
            chk("t6_empty_valid", fetch_result_valid, 0);
        end
        chk("t6_addr_held", imem_req_address, 25'h300);
        for (int i = 0; i < 8; i++) cycle(STALL, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(FetchOperation'(2'b11), '0, 1'b1);
            chk("t6_op11_valid", fetch_result_valid, 1);
            chk("t6_op11_head", fetch_result.program_counter, 25'h300);
            chk("t6_op11_full", imem_req_valid, 0);
        end
        for (int i = 0; i < 8; i++) cycle(DEQUEUE, '0, 1'b1);

        // Random traffic: mixed commands, variable latency, intermittent ready.
        lat_min = 1; lat_max = 4;
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      op = DEQUEUE;
            else if (r < 82) op = STALL;
            else if (r < 92) op = FetchOperation'(2'b11);
            else             op = REDIRECT;
            if ($urandom_range(0, 3) == 0) tgt = Word'(25'h1FFFFFD + $urandom_range(0, 2));
            else                           tgt = Word'($urandom);
            cycle(op, tgt, $urandom_range(0, 3) != 0);
        end
        check_stats("random");

        // Asynchronous reset in the middle of traffic.
        fetch_request.operation = STALL;
        imem_resp_valid         = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_result_valid", fetch_result_valid, 0);
        chk("arst_req_address", imem_req_address, 0);
        chk("arst_result", fetch_result, 0);
        pend_q.delete();
        sb_q.delete();
        exp_addr        = '0;
        epoch++;
        last_due        = -1;
        model_fetched   = 0;
        model_redirects = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_stats("arst");
        lat_min = 1; lat_max = 1;
        expect_first("arst_restart", 25'h0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
